// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the branch resolver: op codes, FSM states and PC step.
package branch_resolver_pkg;

  localparam logic [2:0] BR_BEQ = 3'd0;
  localparam logic [2:0] BR_BNE = 3'd1;
  localparam logic [2:0] BR_BLT = 3'd2;
  localparam logic [2:0] BR_BGE = 3'd3;
  localparam logic [2:0] BR_BLE = 3'd4;
  localparam logic [2:0] BR_BGT = 3'd5;
  localparam logic [2:0] BR_JMP = 3'd6;
  localparam logic [2:0] BR_NOP = 3'd7;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/branch_resolver_cond.sv
// Combinational branch condition decode from comparer NotEqual/LessThan flags.
module branch_resolver_cond
  import branch_resolver_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_ne,
  input  logic       i_lt,
  output logic       o_taken_c
);

  // The ne=0/lt=1 pair never comes from the comparer; it is decoded literally.
  always_comb begin
    o_taken_c = 1'b0;
    case (i_op)
      BR_BEQ:  o_taken_c = !i_ne;
      BR_BNE:  o_taken_c = i_ne;
      BR_BLT:  o_taken_c = i_lt;
      BR_BGE:  o_taken_c = !i_lt;
      BR_BLE:  o_taken_c = i_lt | !i_ne;
      BR_BGT:  o_taken_c = !i_lt & i_ne;
      BR_JMP:  o_taken_c = 1'b1;
      default: o_taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Registered branch decision/redirect with post-redirect squash window.
// Optional BRANCH_STATS_EN adds saturating branch/taken counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned OFFW          = 16,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_ne,
  input  logic            in_lt,
  input  logic [XLEN-1:0] in_pc,
  input  logic [OFFW-1:0] in_off,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            squash
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  localparam int unsigned CNTW = 4;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            r_out_valid;
  logic            r_out_taken;
  logic [XLEN-1:0] r_out_target;
  logic            r_squash;
  logic            w_taken;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_squash_go;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_off_ext;
  logic [XLEN-1:0] w_tgt_taken;

  branch_resolver_cond u_cond (
    .i_op      (in_op),
    .i_ne      (in_ne),
    .i_lt      (in_lt),
    .o_taken_c (w_taken)
  );

  assign w_seq       = in_pc + XLEN'(PC_INCR);
  assign w_off_ext   = {{(XLEN-OFFW){in_off[OFFW-1]}}, in_off};
  assign w_tgt_taken = w_seq + (w_off_ext << 2);

  assign in_ready    = (r_state == ST_IDLE) & (!r_out_valid | out_ready);
  assign w_in_xfer   = in_valid & in_ready;
  assign w_out_xfer  = r_out_valid & out_ready;
  assign w_squash_go = w_out_xfer & r_out_taken;

  assign out_valid   = r_out_valid;
  assign out_taken   = r_out_taken;
  assign out_target  = r_out_target;
  assign squash      = r_squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Squash counter runs SQUASH_CYCLES..1, leaving on the cycle it reads 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == ST_IDLE) begin
      if (w_squash_go) begin
        w_state_nxt = ST_SQUASH;
        w_cnt_nxt   = CNTW'(SQUASH_CYCLES);
      end
    end else begin
      if (r_cnt <= CNTW'(1)) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt - CNTW'(1);
      end
    end
  end

  // An input accepted alongside a taken redirect is held but never presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_taken  <= 1'b0;
      r_out_target <= '0;
      r_squash     <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_out_valid  <= !w_squash_go;
        r_out_taken  <= w_taken;
        r_out_target <= w_taken ? w_tgt_taken : w_seq;
      end else if (w_out_xfer) begin
        r_out_valid  <= 1'b0;
      end
      r_squash <= (w_state_nxt == ST_SQUASH);
    end
  end

`ifdef BRANCH_STATS_EN
  logic r_is_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_branch   <= 1'b0;
      stat_branches <= '0;
      stat_taken    <= '0;
    end else begin
      if (w_in_xfer) begin
        r_is_branch <= (in_op != BR_NOP);
      end
      if (w_out_xfer && r_is_branch && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (w_out_xfer && r_out_taken && (stat_taken != 32'hFFFF_FFFF)) begin
        stat_taken <= stat_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed requests push expectations,
// a negedge monitor pops and compares on every output transfer.
module tb_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_ne;
  logic        in_lt;
  logic [31:0] in_pc;
  logic [15:0] in_off;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic        squash;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
`endif

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  branch_resolver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_ne      (in_ne),
    .in_lt      (in_lt),
    .in_pc      (in_pc),
    .in_off     (in_off),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_taken  (out_taken),
    .out_target (out_target),
    .squash     (squash)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_taken    (stat_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Output-transfer monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_taken", 32'(out_taken), 32'(e.taken));
          chk("out_target", out_target, e.target);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic ne, input logic lt,
                      input logic [31:0] pc, input logic [15:0] off,
                      input logic exp_taken, input logic [31:0] exp_tgt, input bit push);
    exp_t e;
    bit   ok;
    in_valid = 1'b1;
    in_op    = op;
    in_ne    = ne;
    in_lt    = lt;
    in_pc    = pc;
    in_off   = off;
    ok       = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end else if (push) begin
      e.taken  = exp_taken;
      e.target = exp_tgt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd7;
    in_ne     = 1'b0;
    in_lt     = 1'b0;
    in_pc     = '0;
    in_off    = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_squash", 32'(squash), 32'd0);
    chk("rst_target", out_target, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // BEQ taken: 0x100 + 4 + 4*4 = 0x114, then two squash cycles
    send(3'd0, 1'b0, 1'b0, 32'h100, 16'h0004, 1'b1, 32'h114, 1'b1);
    chk("beq_valid", 32'(out_valid), 32'd1);
    idle(1);
    chk("sq1", 32'(squash), 32'd1);
    chk("sq1_in_ready", 32'(in_ready), 32'd0);
    idle(1);
    chk("sq2", 32'(squash), 32'd1);
    chk("sq2_in_ready", 32'(in_ready), 32'd0);
    idle(1);
    chk("sq_end", 32'(squash), 32'd0);
    chk("sq_end_in_ready", 32'(in_ready), 32'd1);

    // BLT not taken, then BGT taken with negative offset
    send(3'd2, 1'b1, 1'b0, 32'h200, 16'hFFFF, 1'b0, 32'h204, 1'b1);
    idle(2);
    chk("blt_no_squash", 32'(squash), 32'd0);
    send(3'd5, 1'b1, 1'b0, 32'h200, 16'hFFFF, 1'b1, 32'h200, 1'b1);
    idle(4);

    // Backpressure: BNE taken 0x300+4+8 = 0x30C held for 3 cycles
    out_ready = 1'b0;
    send(3'd1, 1'b1, 1'b0, 32'h300, 16'h0002, 1'b1, 32'h30C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_target", out_target, 32'h30C);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      idle(1);
    end
    out_ready = 1'b1;
    idle(1);
    chk("bp_single", 32'(out_valid), 32'd0);
    idle(3);

    // Wrap: JMP from 0xFFFFFFFC, +4 +4 wraps to 0x4
    send(3'd6, 1'b0, 1'b0, 32'hFFFF_FFFC, 16'h0001, 1'b1, 32'h4, 1'b1);
    idle(1);
    chk("wrap_squash", 32'(squash), 32'd1);
    idle(3);

    // NOP: not taken, seq target, no squash; BLE with ne=0 is taken
    send(3'd7, 1'b0, 1'b1, 32'h400, 16'h0010, 1'b0, 32'h404, 1'b1);
    idle(2);
    chk("nop_no_squash", 32'(squash), 32'd0);
    send(3'd4, 1'b0, 1'b0, 32'h440, 16'hFFFE, 1'b1, 32'h43C, 1'b1);
    idle(4);

    // Taken out-transfer with simultaneous input: second entry is dropped
    send(3'd0, 1'b0, 1'b0, 32'h500, 16'h0000, 1'b1, 32'h504, 1'b1);
    send(3'd1, 1'b1, 1'b0, 32'h600, 16'h0000, 1'b1, 32'h604, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drop_no_valid", 32'(out_valid), 32'd0);
      idle(1);
    end
    chk("drop_in_ready", 32'(in_ready), 32'd1);
    chk("drop_q_empty", 32'(q.size()), 32'd0);

    // Async reset mid-cycle with a pending decision
    out_ready = 1'b0;
    send(3'd2, 1'b1, 1'b1, 32'h700, 16'h0000, 1'b1, 32'h704, 1'b1);
    chk("pend_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_taken", 32'(out_taken), 32'd0);
    chk("arst_target", out_target, 32'd0);
    chk("arst_squash", 32'(squash), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(1);
    chk("arst_in_ready", 32'(in_ready), 32'd1);

`ifdef BRANCH_STATS_EN
    chk("stat_rst_b", stat_branches, 32'd0);
    send(3'd0, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b1, 32'h4, 1'b1);
    idle(4);
    send(3'd1, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 32'h4, 1'b1);
    idle(2);
    send(3'd2, 1'b1, 1'b1, 32'h0, 16'h0000, 1'b1, 32'h4, 1'b1);
    idle(4);
    send(3'd7, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 32'h4, 1'b1);
    idle(2);
    send(3'd3, 1'b1, 1'b1, 32'h0, 16'h0000, 1'b0, 32'h4, 1'b1);
    idle(2);
    send(3'd6, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b1, 32'h4, 1'b1);
    idle(4);
    send(3'd7, 1'b1, 1'b0, 32'h0, 16'h0000, 1'b0, 32'h4, 1'b1);
    idle(2);
    chk("stat_branches", stat_branches, 32'd5);
    chk("stat_taken", stat_taken, 32'd3);
`endif

    idle(2);
    chk("final_q_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the NotEqual/LessThan flag pair produced by the 32-bit signed comparer and turns it into a registered branch decision and redirect target for the fetch stage.
- Sits between the compare stage and PC/fetch logic.
- Handshake on both sides; after every taken redirect, runs a squash window that holds off new requests.

Parameters:
- XLEN, 32, PC and target width.
- OFFW, 16, branch offset width (word offset, sign-extended).
- SQUASH_CYCLES, 2, cycles `squash` stays high after a taken branch is accepted downstream (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_op  in  3  0=BEQ, 1=BNE, 2=BLT, 3=BGE, 4=BLE, 5=BGT, 6=JMP, 7=NOP
- in_ne  in  1  comparer NotEqual (A!=B)
- in_lt  in  1  comparer LessThan (A<B, signed)
- in_pc  in  XLEN  PC of branch
- in_off  in  OFFW  signed word offset
- out_valid  out  1  decision valid
- out_ready  in  1  consumer accepts decision
- out_taken  out  1  branch taken
- out_target  out  XLEN  next PC
- squash  out  1  flush younger instructions

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_taken=0, out_target=0, squash=0, FSM=IDLE, squash counter=0.
- Leaving reset is synchronous to clk.
- Condition decode:
  - BEQ = !ne; BNE = ne; BLT = lt; BGE = !lt; BLE = lt | !ne; BGT = !lt & ne; JMP = 1; NOP = 0.
  - A flag pair of ne=0, lt=1 is not produced by the comparer. If it arrives, decode it literally as above. No checking is done.
- Target arithmetic:
  - seq = in_pc + 4.
  - Taken target = seq + (sign_extend(in_off) << 2), computed modulo 2^XLEN. Wrap-around is silent.
  - Not-taken target = seq.
- Output register:
  - in_ready = (state==IDLE) & (!out_valid | out_ready).
  - An input transfer (in_valid & in_ready) loads out_taken and out_target and sets out_valid the next cycle. Latency is 1 cycle.
  - Output transfer: out_valid & out_ready. out_valid clears after it unless a new input transfers in the same cycle.
  - out_* are stable while out_valid=1 and out_ready=0.
- FSM:
  - IDLE: on an output transfer with out_taken=1, go to SQUASH, load counter=SQUASH_CYCLES, squash=1 from the next cycle.
  - SQUASH: squash=1 and in_ready=0. The counter decrements each cycle. On the cycle it reaches 1, return to IDLE next cycle.
  - Squash is therefore high for exactly SQUASH_CYCLES cycles.
- Simultaneous taken out-transfer and input transfer in the same cycle:
  - The input is accepted.
  - Its decision is held in the output register.
  - out_valid is forced to 0 while in SQUASH. The squash discards it: the entry is dropped and never presented.
- NOP requests produce out_taken=0 and out_target=in_pc+4, and never trigger SQUASH.
- Reset asserted mid-squash or with a pending output aborts immediately to the reset values. The pending decision is lost.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds outputs stat_branches[31:0] and stat_taken[31:0]. Each increments on an output transfer: stat_branches for any op except NOP, stat_taken when out_taken=1.
  - Both saturate at 0xFFFFFFFF and are reset to 0 by rst_n.
- Not defined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package/include (`common/` header):
  - op encodings BR_BEQ..BR_NOP.
  - State encodings ST_IDLE, ST_SQUASH.
  - PC_INCR=4.
- One natural sub-module: branch_cond (combinational in_op, in_ne, in_lt -> taken), reusable by the ALU decoder.
- Target adder uses the existing 32-bit adder from alu/.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with out_valid=1 -> all outputs 0 asynchronously; in_ready=1 after release.
- BEQ, ne=0, pc=0x100, off=0x0004, out_ready=1 -> next cycle out_valid=1, out_taken=1, target=0x114; squash high exactly 2 cycles; in_ready=0 during squash.
- BLT, ne=1, lt=0, pc=0x200, off=0xFFFF -> out_taken=0, target=0x204, no squash. Repeat with BGT -> taken, target=0x200.
- Backpressure: out_ready=0 for 3 cycles -> out_* stable, in_ready=0; release -> single transfer.
- Wrap: JMP pc=0xFFFFFFFC, off=0x0001 -> target=0x00000004, taken, squash.
- BRANCH_STATS_EN: 5 branches (3 taken) plus 2 NOPs -> stat_branches=5, stat_taken=3.
